// File: rtl/nanolab_serial_pkg.sv
// Shared constants for the serial word transmitter.
//   DEFAULT_DATA_W : default frame width in bits
//   ST_*           : 3-bit binary encodings of the transmit FSM states
package nanolab_serial_pkg;

   localparam int unsigned DEFAULT_DATA_W = 24;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

endpackage : nanolab_serial_pkg

// File: rtl/edge_det.sv
// Registered edge detector for a square wave that already lives in the clk domain.
// Ports:
//   clk, reset  : system clock, asynchronous active-high reset
//   sig_i       : square wave to watch (registered upstream)
//   rise_c_o    : high for one cycle after sig_i goes 0->1
//   fall_c_o    : high for one cycle after sig_i goes 1->0
module edge_det (
   input  logic clk,
   input  logic reset,
   input  logic sig_i,
   output logic rise_c_o,
   output logic fall_c_o
);

   logic sig_q;

   // One-cycle history of the input.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_i;
      end
   end

   // sig_i is itself a flop output, so these stay register-to-register paths.
   assign rise_c_o = sig_i & ~sig_q;
   assign fall_c_o = ~sig_i & sig_q;

endmodule : edge_det

// File: rtl/serial_word_tx.sv
// Serialises one parallel word into a cs_n/sclk/mosi frame, paced by the
// divided square wave div_clk. sclk follows div_clk edges; mosi changes on
// sclk fall so it is stable around every sclk rise.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   div_clk    : rate reference from the clock divider (clk domain)
//   start      : frame request, only honoured while idle
//   data_in    : word captured on acceptance
//   busy       : frame in progress (cycle after acceptance through done)
//   done       : one-cycle pulse at end of frame
//   cs_n       : chip select, active low
//   sclk       : serial clock, idles low
//   mosi       : serial data
module serial_word_tx
   import nanolab_serial_pkg::*;
#(
   parameter int unsigned DATA_W    = DEFAULT_DATA_W,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              div_clk,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   output logic              busy,
   output logic              done,
   output logic              cs_n,
   output logic              sclk,
   output logic              mosi
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);
   // Bit position that is always the next one on the wire.
   localparam int unsigned LEAD  = MSB_FIRST ? DATA_W - 1 : 0;

   logic              rise_c;
   logic              fall_c;

   logic [2:0]        state_q,   state_d;
   logic [DATA_W-1:0] shreg_q,   shreg_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              busy_q,    busy_d;
   logic              done_q,    done_d;
   logic              cs_n_q,    cs_n_d;
   logic              sclk_q,    sclk_d;
   logic              mosi_q,    mosi_d;
   logic [DATA_W-1:0] shreg_rot_c;

   // div_clk edge strobes.
   edge_det u_edge_det (
      .clk      (clk),
      .reset    (reset),
      .sig_i    (div_clk),
      .rise_c_o (rise_c),
      .fall_c_o (fall_c)
   );

   // Rotate rather than shift: the wrapped bit is never sent, and every
   // register bit stays in use for either bit order.
   assign shreg_rot_c = MSB_FIRST ? {shreg_q[DATA_W-2:0], shreg_q[DATA_W-1]}
                                  : {shreg_q[0], shreg_q[DATA_W-1:1]};

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cs_n_q    <= cs_n_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      cs_n_d    = cs_n_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               shreg_d   = data_in;
               bit_cnt_d = CNT_W'(DATA_W);
               busy_d    = 1'b1;
               cs_n_d    = 1'b0;
               mosi_d    = data_in[LEAD];
               state_d   = ST_SETUP;
            end
         end

         // Waiting for a fall gives the first bit a half-period of setup.
         ST_SETUP: begin
            if (fall_c) begin
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            if (rise_c) begin
               sclk_d = 1'b1;
               if (bit_cnt_q != '0) begin
                  bit_cnt_d = bit_cnt_q - CNT_W'(1);
               end
            end else if (fall_c) begin
               sclk_d = 1'b0;
               if (bit_cnt_q == '0) begin
                  state_d = ST_HOLD;
               end else begin
                  shreg_d = shreg_rot_c;
                  mosi_d  = shreg_rot_c[LEAD];
               end
            end
         end

         // Half-period of cs hold after the last sclk fall.
         ST_HOLD: begin
            if (rise_c) begin
               cs_n_d  = 1'b1;
               mosi_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;
   assign cs_n = cs_n_q;
   assign sclk = sclk_q;
   assign mosi = mosi_q;

endmodule : serial_word_tx

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: one MSB-first and one LSB-first instance share
// all inputs; a monitor rebuilds each frame from the wire and compares it to
// the word the bench last requested.
module tb_serial_word_tx;

   localparam int unsigned W = 8;

   logic         clk     = 1'b0;
   logic         reset   = 1'b1;
   logic         div_clk = 1'b0;
   logic         div_run = 1'b1;
   logic         start   = 1'b0;
   logic [W-1:0] data_in = '0;
   int           half    = 4;
   int           dcnt    = 0;

   logic [1:0]   busy_w, done_w, cs_w, sclk_w, mosi_w;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] exp_word = '0;

   // Monitor state, index 0 = MSB-first instance, 1 = LSB-first instance.
   int           rises  [2] = '{0, 0};
   int           frames [2] = '{0, 0};
   int           gap    [2] = '{0, 0};
   logic         in_frame   [2] = '{1'b0, 1'b0};
   logic         ever_frame [2] = '{1'b0, 1'b0};
   logic [1:0]   prev_cs   = 2'b11;
   logic [1:0]   prev_sclk = 2'b00;
   logic [1:0]   prev_done = 2'b00;
   logic [W-1:0] rx [2];

   always #5 clk = ~clk;

   // Clock divider model: registered square wave, half-period = half clks.
   always @(posedge clk) begin
      if (div_run) begin
         if (dcnt >= half - 1) begin
            dcnt    <= 0;
            div_clk <= ~div_clk;
         end else begin
            dcnt <= dcnt + 1;
         end
      end
   end

   serial_word_tx #(.DATA_W(W), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .reset(reset), .div_clk(div_clk), .start(start), .data_in(data_in),
      .busy(busy_w[0]), .done(done_w[0]), .cs_n(cs_w[0]), .sclk(sclk_w[0]), .mosi(mosi_w[0])
   );

   serial_word_tx #(.DATA_W(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset(reset), .div_clk(div_clk), .start(start), .data_in(data_in),
      .busy(busy_w[1]), .done(done_w[1]), .cs_n(cs_w[1]), .sclk(sclk_w[1]), .mosi(mosi_w[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: bit sent at the k-th sclk rise for a given word and bit order.
   function automatic logic [W-1:0] serial_order(input logic [W-1:0] w, input int m);
      logic [W-1:0] s;
      for (int k = 0; k < int'(W); k++) begin
         s[k] = (m == 0) ? w[int'(W) - 1 - k] : w[k];
      end
      return s;
   endfunction

   task automatic mon(input int m);
      logic [W-1:0] exp_s;
      if (reset) begin
         in_frame[m]  = 1'b0;
         prev_cs[m]   = 1'b1;
         prev_sclk[m] = 1'b0;
         prev_done[m] = 1'b0;
         gap[m]       = 0;
         return;
      end
      if (prev_done[m]) begin
         check($sformatf("busy_after_done%0d", m), 32'(busy_w[m]), 32'h0);
         check($sformatf("done_width%0d", m), 32'(done_w[m]), 32'h0);
      end
      if (prev_cs[m] && !cs_w[m]) begin
         if (ever_frame[m]) check($sformatf("cs_gap%0d", m), 32'(gap[m] >= 2), 32'h1);
         in_frame[m] = 1'b1;
         rises[m]    = 0;
         rx[m]       = '0;
      end
      if (cs_w[m]) gap[m]++;
      else         gap[m] = 0;
      if (in_frame[m] && !cs_w[m] && sclk_w[m] && !prev_sclk[m]) begin
         if (rises[m] < int'(W)) rx[m][3'(rises[m])] = mosi_w[m];
         rises[m]++;
      end
      if (in_frame[m] && !cs_w[m] && (exp_word == 8'hFF || exp_word == 8'h00))
         check($sformatf("mosi_const%0d", m), 32'(mosi_w[m]), 32'(exp_word[0]));
      if (in_frame[m] && cs_w[m] && !prev_cs[m]) begin
         exp_s = serial_order(exp_word, m);
         check($sformatf("rise_count%0d", m), 32'(rises[m]), 32'(W));
         check($sformatf("frame_bits%0d", m), 32'(rx[m]), 32'(exp_s));
         check($sformatf("done_at_end%0d", m), 32'(done_w[m]), 32'h1);
         check($sformatf("busy_at_end%0d", m), 32'(busy_w[m]), 32'h1);
         check($sformatf("sclk_at_end%0d", m), 32'(sclk_w[m]), 32'h0);
         in_frame[m]   = 1'b0;
         ever_frame[m] = 1'b1;
         frames[m]++;
      end else if (done_w[m]) begin
         check($sformatf("stray_done%0d", m), 32'(done_w[m]), 32'h0);
      end
      prev_cs[m]   = cs_w[m];
      prev_sclk[m] = sclk_w[m];
      prev_done[m] = done_w[m];
   endtask

   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) mon(m);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_frames(input int target, input int limit, input string tag);
      int n = 0;
      while (frames[0] < target && n < limit) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({tag, "_timeout"}, 32'(frames[0] >= target), 32'h1);
   endtask

   task automatic wait_rises(input int target, input int limit);
      int n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!(in_frame[0] && rises[0] >= target) && n < limit);
      check("rise_wait_timeout", 32'(in_frame[0] && rises[0] >= target), 32'h1);
   endtask

   // Request a frame and check one-cycle acceptance latency and the first bit.
   task automatic begin_frame(input logic [W-1:0] w);
      logic [W-1:0] s0, s1;
      s0 = serial_order(w, 0);
      s1 = serial_order(w, 1);
      tick();
      start    = 1'b1;
      data_in  = w;
      exp_word = w;
      tick();
      start   = 1'b0;
      data_in = W'($urandom);
      check("cs_n_latency", 32'(cs_w), 32'h0);
      check("busy_latency", 32'(busy_w), 32'h3);
      check("first_bit_msb", 32'(mosi_w[0]), 32'(s0[0]));
      check("first_bit_lsb", 32'(mosi_w[1]), 32'(s1[0]));
   endtask

   task automatic send(input logic [W-1:0] w);
      int f0;
      f0 = frames[0];
      begin_frame(w);
      wait_frames(f0 + 1, 4000, "send");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int   f0;
      logic [1:0] s_cs, s_sclk, s_mosi;
      logic changed, bad_busy;

      // Reset state
      repeat (3) tick();
      check("rst_busy", 32'(busy_w), 32'h0);
      check("rst_done", 32'(done_w), 32'h0);
      check("rst_cs_n", 32'(cs_w), 32'h3);
      check("rst_sclk", 32'(sclk_w), 32'h0);
      check("rst_mosi", 32'(mosi_w), 32'h0);
      reset = 1'b0;
      repeat (4) tick();

      // Basic frames, both bit orders, constant patterns
      send(8'hA5);
      send(8'h01);
      send(8'hFF);
      send(8'h00);

      // start re-pulsed mid-frame with different data is ignored
      f0 = frames[0];
      begin_frame(8'hA5);
      wait_rises(3, 2000);
      tick();
      start   = 1'b1;
      data_in = 8'h3C;
      repeat (2) tick();
      start = 1'b0;
      wait_frames(f0 + 1, 4000, "midstart");
      repeat (60) tick();
      check("midstart_one_frame", 32'(frames[0] - f0), 32'h1);
      check("midstart_one_frame_lsb", 32'(frames[1] - f0), 32'h1);
      check("midstart_idle_cs", 32'(cs_w), 32'h3);

      // start held high: back-to-back frames
      f0 = frames[0];
      tick();
      start    = 1'b1;
      data_in  = 8'hA5;
      exp_word = 8'hA5;
      wait_frames(f0 + 3, 6000, "held");
      start = 1'b0;
      repeat (60) tick();
      check("held_frames", 32'(frames[0] - f0), 32'h3);
      check("held_idle_busy", 32'(busy_w), 32'h0);

      // reset mid-frame after the 3rd sclk rise
      f0 = frames[0];
      begin_frame(8'hA5);
      wait_rises(3, 2000);
      reset = 1'b1;
      #1;
      check("midrst_cs_n", 32'(cs_w), 32'h3);
      check("midrst_sclk", 32'(sclk_w), 32'h0);
      check("midrst_busy", 32'(busy_w), 32'h0);
      check("midrst_done", 32'(done_w), 32'h0);
      repeat (3) tick();
      reset = 1'b0;
      repeat (5) tick();
      check("midrst_no_frame", 32'(frames[0] - f0), 32'h0);
      send(8'hA5);

      // div_clk frozen during SHIFT
      f0 = frames[0];
      begin_frame(8'hC3);
      wait_rises(4, 2000);
      div_run = 1'b0;
      repeat (3) tick();
      s_cs     = cs_w;
      s_sclk   = sclk_w;
      s_mosi   = mosi_w;
      changed  = 1'b0;
      bad_busy = 1'b0;
      repeat (100) begin
         tick();
         if (cs_w != s_cs || sclk_w != s_sclk || mosi_w != s_mosi) changed = 1'b1;
         if (busy_w != 2'b11) bad_busy = 1'b1;
      end
      check("freeze_static", 32'(changed), 32'h0);
      check("freeze_busy", 32'(bad_busy), 32'h0);
      check("freeze_cs_low", 32'(s_cs), 32'h0);
      div_run = 1'b1;
      wait_frames(f0 + 1, 4000, "freeze");

      // Randomized words and divider rates
      for (int i = 0; i < 12; i++) begin
         half = int'($urandom_range(5, 2));
         send(W'($urandom));
      end

      repeat (10) tick();
      check("frame_count_match", 32'(frames[1]), 32'(frames[0]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_serial_word_tx
